div_issue_ctrl: RTL

Controller that sequences the single shared iterative divider between the two issue slots of the dual-issue pipeline. It latches both slots' divide requests and launches them on the divider in program order (slot0 first). It collects the quotient or remainder for each slot and presents per-slot writeback results to EX2_WB. It also asserts `stall_divider` to freeze the front of the pipeline while divides are outstanding, and aborts cleanly on flush.

---
 rtl/div_issue_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - sequences the shared iterative divider across both issue slots
module div_issue_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        ex_allowin,
  input  logic        req0_valid,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_src1,
  input  logic [31:0] req0_src2,
  input  logic [4:0]  req0_rd,
  input  logic        req1_valid,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_src1,
  input  logic [31:0] req1_src2,
  input  logic [4:0]  req1_rd,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_cancel,
  input  logic        div_busy,
  input  logic        div_done,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  output logic        stall_divider,
  output logic        div_ready,
  output logic        wb0_valid,
  output logic [4:0]  wb0_rd,
  output logic [31:0] wb0_data,
  output logic        wb1_valid,
  output logic [4:0]  wb1_rd,
  output logic [31:0] wb1_data,
  output logic        div_err
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, DONE} state_t;
  state_t state;

  logic [1:0]    op0_q, op1_q;
  logic [31:0]   a0_q, b0_q, a1_q, b1_q;
  logic [4:0]    rd0_q, rd1_q;
  logic          pend0, pend1;
  logic [CW-1:0] cnt;
  logic [31:0]   res0, res1;

  assign res0 = op0_q[0] ? div_remainder : div_quotient;
  assign res1 = op1_q[0] ? div_remainder : div_quotient;

  assign div_ready     = (state == DONE);
  assign stall_divider = ((state != IDLE) && (state != DONE)) ||
                         ((state == IDLE) && (req0_valid || req1_valid) && !flush);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      div_start    <= 1'b0;
      div_cancel   <= 1'b0;
      div_signed   <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      wb0_valid    <= 1'b0;
      wb0_rd       <= '0;
      wb0_data     <= '0;
      wb1_valid    <= 1'b0;
      wb1_rd       <= '0;
      wb1_data     <= '0;
      div_err      <= 1'b0;
      op0_q        <= '0;
      op1_q        <= '0;
      a0_q         <= '0;
      b0_q         <= '0;
      a1_q         <= '0;
      b1_q         <= '0;
      rd0_q        <= '0;
      rd1_q        <= '0;
      pend0        <= 1'b0;
      pend1        <= 1'b0;
      cnt          <= '0;
    end else begin
      div_start  <= 1'b0;
      div_cancel <= 1'b0;
      if (flush) begin
        // flush beats everything, including a div_done landing this cycle
        state      <= IDLE;
        wb0_valid  <= 1'b0;
        wb1_valid  <= 1'b0;
        pend0      <= 1'b0;
        pend1      <= 1'b0;
        cnt        <= '0;
        div_cancel <= (state inside {ISSUE0, WAIT0, ISSUE1, WAIT1});
      end else begin
        case (state)
          IDLE: begin
            if (req0_valid || req1_valid) begin
              op0_q <= req0_op;
              a0_q  <= req0_src1;
              b0_q  <= req0_src2;
              rd0_q <= req0_rd;
              op1_q <= req1_op;
              a1_q  <= req1_src1;
              b1_q  <= req1_src2;
              rd1_q <= req1_rd;
              pend0 <= req0_valid;
              pend1 <= req1_valid;
              state <= req0_valid ? ISSUE0 : ISSUE1;
            end
          end
          ISSUE0: begin
            if (!div_busy) begin
              div_start    <= 1'b1;
              div_signed   <= ~op0_q[1];
              div_dividend <= a0_q;
              div_divisor  <= b0_q;
              cnt          <= '0;
              state        <= WAIT0;
            end
          end
          ISSUE1: begin
            if (!div_busy) begin
              div_start    <= 1'b1;
              div_signed   <= ~op1_q[1];
              div_dividend <= a1_q;
              div_divisor  <= b1_q;
              cnt          <= '0;
              state        <= WAIT1;
            end
          end
          WAIT0, WAIT1: begin
            cnt <= cnt + CW'(1);
            if (div_done) begin
              if (state == WAIT0) begin
                wb0_data  <= res0;
                wb0_rd    <= rd0_q;
                // slot1 is younger, so a same-rd pair only writes back slot1
                wb0_valid <= (rd0_q != 5'd0) && !(pend1 && (rd1_q == rd0_q));
                pend0     <= 1'b0;
                state     <= pend1 ? ISSUE1 : DONE;
              end else begin
                wb1_data  <= res1;
                wb1_rd    <= rd1_q;
                wb1_valid <= (rd1_q != 5'd0);
                pend1     <= 1'b0;
                state     <= DONE;
              end
            end else if (cnt == CW'(TIMEOUT - 1)) begin
              div_err    <= 1'b1;
              div_cancel <= 1'b1;
              wb0_valid  <= 1'b0;
              wb1_valid  <= 1'b0;
              pend0      <= 1'b0;
              pend1      <= 1'b0;
              state      <= DONE;
            end
          end
          DONE: begin
            if (ex_allowin) begin
              wb0_valid <= 1'b0;
              wb1_valid <= 1'b0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
